rally_sequencer: RTL and testbench
==================================

// Module: rally_sequencer
// PURPOSE
//  Game-flow controller for the two-player volleyball screen. Sequences
//  serve/rally/point/game-over phases, keeps both scores and gates the
//  player/ball motion datapath (physics_en, ball_reset, players_reset).
//  Sits between KeyboardDecoder (start key) and the position/sprite logic.
// PARAMETERS
//  WIN_SCORE    15       points needed to win (1..31)
//  FLOOR_Y      200      ball_y at/above which the ball has landed
//  NET_X        160      net column; ball_x < NET_X is the left (p1) court
//  TICK_DIV     1666667  clk cycles per frame tick (60 Hz @ 100 MHz)
//  SERVE_TICKS  60       frame ticks frozen before each serve
//  POINT_TICKS  90       frame ticks frozen after a point
// PORTS
//  clk           in   1   system clock, 100 MHz
//  rst           in   1   asynchronous, active-low reset (rst==0 resets)
//  start         in   1   1-cycle pulse, start/restart key
//  ball_x        in   16  ball centre x, 320x240 coordinates
//  ball_y        in   16  ball centre y, 320x240 coordinates
//  state         out  3   0 IDLE,1 SERVE,2 RALLY,3 POINT,4 OVER,5 PAUSE
//  score_p1      out  5   left player score
//  score_p2      out  5   right player score
//  serve_side    out  1   0 = p1 serves, 1 = p2 serves
//  physics_en    out  1   level; motion datapath may update positions
//  ball_reset    out  1   1-cycle pulse: reload ball above serve_side
//  players_reset out  1   1-cycle pulse: reload both players' home x/y
//  winner        out  2   0 none, 1 p1, 2 p2
//  frame_tick    out  1   1-cycle pulse every TICK_DIV clk cycles
// BEHAVIOUR
//  Reset: state=IDLE, scores=0, serve_side=0, winner=0, all pulses and
//   physics_en=0, tick and phase counters=0.
//  frame_tick: free-running divider, asserted when count==TICK_DIV-1,
//   then count wraps to 0; runs in every state except PAUSE.
//  All outputs are registered; transitions take effect the next clk edge.
//  IDLE: start -> SERVE; players_reset and ball_reset pulse that cycle.
//  SERVE: physics_en=0; counts frame_ticks; after SERVE_TICKS -> RALLY.
//  RALLY: physics_en=1; first cycle with ball_y>=FLOOR_Y -> POINT.
//   ball_x<NET_X gives the point to p2; ball_x>=NET_X (incl. ==NET_X)
//   gives it to p1. Scorer's score +1 in the transition cycle;
//   serve_side <= scorer.
//  POINT: physics_en=0; after POINT_TICKS frame_ticks: if the scorer's
//   score==WIN_SCORE -> OVER, winner set; else -> SERVE, pulsing
//   ball_reset and players_reset.
//  OVER: scores and winner held; start -> scores=0, winner=0,
//   serve_side=0, pulses both resets -> SERVE.
//  start in SERVE/RALLY/POINT is ignored. Scores never exceed WIN_SCORE.
//  Phase counter clears on every state entry. Reset asserted mid-phase
//   returns to IDLE immediately (asynchronous), independent of clk.
// CONFIGURATION
//  RALLY_PAUSE_EN defined: adds input pause (1-cycle pulse). In RALLY,
//   pause -> PAUSE (physics_en=0, divider and counters frozen); pause in
//   PAUSE -> RALLY, resuming the counts. pause elsewhere is ignored.
//  Undefined: no pause port; state 5 unreachable.
// TESTING (TICK_DIV=4, SERVE_TICKS=2, POINT_TICKS=2, WIN_SCORE=3)
//  rst low mid-RALLY -> state=0, scores=0, physics_en=0 at once.
//  start in IDLE -> ball_reset and players_reset high 1 cycle;
//   RALLY after 2 frame_ticks.
//  RALLY, ball_y=200, ball_x=100 -> score_p2=1, serve_side=1, POINT.
//  RALLY, ball_y=210, ball_x=160 -> score_p1 +1 (net column = right).
//  p1 reaches 3 -> OVER, winner=1; start -> scores=0, SERVE.
//  RALLY_PAUSE_EN: pause in RALLY -> no frame_tick while paused;
//   second pause resumes RALLY.

Source files
------------

// File: rtl/rally_sequencer.sv
// Game-flow controller for the two-player volleyball screen: serve/rally/point/over sequencing,
// scoring and motion gating. Define RALLY_PAUSE_EN to add the pause input and PAUSE state.
`timescale 1ns/1ps

module rally_sequencer #(
    parameter int unsigned WIN_SCORE   = 15,
    parameter int unsigned FLOOR_Y     = 200,
    parameter int unsigned NET_X       = 160,
    parameter int unsigned TICK_DIV    = 1666667,
    parameter int unsigned SERVE_TICKS = 60,
    parameter int unsigned POINT_TICKS = 90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ball_x,
    input  logic [15:0] ball_y,
`ifdef RALLY_PAUSE_EN
    input  logic        pause,
`endif
    output logic [2:0]  state,
    output logic [4:0]  score_p1,
    output logic [4:0]  score_p2,
    output logic        serve_side,
    output logic        physics_en,
    output logic        ball_reset,
    output logic        players_reset,
    output logic [1:0]  winner,
    output logic        frame_tick
);

    localparam int unsigned DivW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PhMax = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;

    localparam logic [DivW-1:0] DivLast   = DivW'(TICK_DIV - 1);
    localparam logic [PhW-1:0]  ServeLast = PhW'(SERVE_TICKS - 1);
    localparam logic [PhW-1:0]  PointLast = PhW'(POINT_TICKS - 1);
    localparam logic [4:0]      WinScore  = 5'(WIN_SCORE);
    localparam logic [15:0]     FloorY    = 16'(FLOOR_Y);
    localparam logic [15:0]     NetX      = 16'(NET_X);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StRally = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4,
        StPause = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      score_p1_q, score_p1_d;
    logic [4:0]      score_p2_q, score_p2_d;
    logic            serve_q, serve_d;
    logic [1:0]      winner_q, winner_d;
    logic [PhW-1:0]  phase_q, phase_d;
    logic [DivW-1:0] div_q, div_d;
    logic            tick_q, tick_d;
    logic            physics_q, physics_d;
    logic            ball_reset_q, ball_reset_d;
    logic            players_reset_q, players_reset_d;
    logic            freeze;

    always_comb begin
        state_d         = state_q;
        score_p1_d      = score_p1_q;
        score_p2_d      = score_p2_q;
        serve_d         = serve_q;
        winner_d        = winner_q;
        phase_d         = phase_q;
        ball_reset_d    = 1'b0;
        players_reset_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d         = StServe;
                    ball_reset_d    = 1'b1;
                    players_reset_d = 1'b1;
                end
            end
            StServe: begin
                if (tick_q) begin
                    if (phase_q == ServeLast) state_d = StRally;
                    else                      phase_d = phase_q + PhW'(1);
                end
            end
            StRally: begin
                // Landing wins over a pause requested in the same cycle.
                if (ball_y >= FloorY) begin
                    state_d = StPoint;
                    if (ball_x < NetX) begin
                        serve_d = 1'b1;
                        if (score_p2_q != WinScore) score_p2_d = score_p2_q + 5'd1;
                    end else begin
                        serve_d = 1'b0;
                        if (score_p1_q != WinScore) score_p1_d = score_p1_q + 5'd1;
                    end
                end
`ifdef RALLY_PAUSE_EN
                else if (pause) begin
                    state_d = StPause;
                end
`endif
            end
            StPoint: begin
                if (tick_q) begin
                    if (phase_q == PointLast) begin
                        // serve_q already names the player who just scored.
                        if ((serve_q ? score_p2_q : score_p1_q) == WinScore) begin
                            state_d  = StOver;
                            winner_d = serve_q ? 2'd2 : 2'd1;
                        end else begin
                            state_d         = StServe;
                            ball_reset_d    = 1'b1;
                            players_reset_d = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + PhW'(1);
                    end
                end
            end
            StOver: begin
                if (start) begin
                    state_d         = StServe;
                    score_p1_d      = 5'd0;
                    score_p2_d      = 5'd0;
                    winner_d        = 2'd0;
                    serve_d         = 1'b0;
                    ball_reset_d    = 1'b1;
                    players_reset_d = 1'b1;
                end
            end
`ifdef RALLY_PAUSE_EN
            StPause: begin
                if (pause) state_d = StRally;
            end
`endif
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) phase_d = '0;

        physics_d = (state_d == StRally);

`ifdef RALLY_PAUSE_EN
        freeze = (state_d == StPause);
`else
        freeze = 1'b0;
`endif

        div_d  = div_q;
        tick_d = 1'b0;
        if (!freeze) begin
            tick_d = (div_q == DivLast);
            div_d  = (div_q == DivLast) ? '0 : div_q + DivW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            score_p1_q      <= 5'd0;
            score_p2_q      <= 5'd0;
            serve_q         <= 1'b0;
            winner_q        <= 2'd0;
            phase_q         <= '0;
            div_q           <= '0;
            tick_q          <= 1'b0;
            physics_q       <= 1'b0;
            ball_reset_q    <= 1'b0;
            players_reset_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            score_p1_q      <= score_p1_d;
            score_p2_q      <= score_p2_d;
            serve_q         <= serve_d;
            winner_q        <= winner_d;
            phase_q         <= phase_d;
            div_q           <= div_d;
            tick_q          <= tick_d;
            physics_q       <= physics_d;
            ball_reset_q    <= ball_reset_d;
            players_reset_q <= players_reset_d;
        end
    end

    assign state         = state_q;
    assign score_p1      = score_p1_q;
    assign score_p2      = score_p2_q;
    assign serve_side    = serve_q;
    assign winner        = winner_q;
    assign physics_en    = physics_q;
    assign ball_reset    = ball_reset_q;
    assign players_reset = players_reset_q;
    assign frame_tick    = tick_q;

endmodule

// File: tb/tb_rally_sequencer.sv
// Self-checking bench for rally_sequencer: table-driven rally landings with a scoreboard queue,
// plus hand sequences for reset, tick period, start handling, game over and pause.
`timescale 1ns/1ps

module tb_rally_sequencer;

    localparam logic [2:0] SIdle  = 3'd0;
    localparam logic [2:0] SServe = 3'd1;
    localparam logic [2:0] SRally = 3'd2;
    localparam logic [2:0] SPoint = 3'd3;
    localparam logic [2:0] SOver  = 3'd4;
    localparam logic [2:0] SPause = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ball_x = 16'd0;
    logic [15:0] ball_y = 16'd0;
`ifdef RALLY_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic [2:0]  state;
    logic [4:0]  score_p1;
    logic [4:0]  score_p2;
    logic        serve_side;
    logic        physics_en;
    logic        ball_reset;
    logic        players_reset;
    logic [1:0]  winner;
    logic        frame_tick;

    rally_sequencer #(
        .WIN_SCORE   (3),
        .FLOOR_Y     (200),
        .NET_X       (160),
        .TICK_DIV    (4),
        .SERVE_TICKS (2),
        .POINT_TICKS (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
`ifdef RALLY_PAUSE_EN
        .pause         (pause),
`endif
        .state         (state),
        .score_p1      (score_p1),
        .score_p2      (score_p2),
        .serve_side    (serve_side),
        .physics_en    (physics_en),
        .ball_reset    (ball_reset),
        .players_reset (players_reset),
        .winner        (winner),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bx;
        logic [15:0] by;
        logic [4:0]  p1;
        logic [4:0]  p2;
        logic        side;
        logic [2:0]  next;
        logic [1:0]  win;
    } vec_t;

    vec_t vecs[9];
    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (state == tgt) hit = 1'b1;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts frame_ticks sampled while the DUT stays in st; returns at the first other state.
    task automatic count_ticks_in(input logic [2:0] st, input int budget, output int ticks);
        ticks = 0;
        for (int i = 0; i < budget; i++) begin
            if (state != st) break;
            if (frame_tick) ticks++;
            @(negedge clk);
        end
        check("phase_exit", 32'(state != st), 32'd1);
    endtask

    task automatic land_vec(input vec_t v, input string tag);
        vec_t exp;
        int   t;
        ball_x = v.bx;
        ball_y = v.by;
        sb_q.push_back(v);
        @(negedge clk);
        exp = sb_q.pop_front();
        ball_y = 16'd0;
        check({tag, "_state_point"}, 32'(state), 32'(SPoint));
        check({tag, "_score_p1"}, 32'(score_p1), 32'(exp.p1));
        check({tag, "_score_p2"}, 32'(score_p2), 32'(exp.p2));
        check({tag, "_serve_side"}, 32'(serve_side), 32'(exp.side));
        check({tag, "_physics_off"}, 32'(physics_en), 32'd0);
        count_ticks_in(SPoint, 60, t);
        check({tag, "_point_ticks"}, 32'(t), 32'd2);
        check({tag, "_next_state"}, 32'(state), 32'(exp.next));
        check({tag, "_winner"}, 32'(winner), 32'(exp.win));
        check({tag, "_ball_reset"}, 32'(ball_reset), 32'(exp.next == SServe));
        check({tag, "_players_reset"}, 32'(players_reset), 32'(exp.next == SServe));
    endtask

    initial begin
        int t;
        int t0;
        bit hit;

        vecs[0] = '{16'd100, 16'd200,   5'd0, 5'd1, 1'b1, SServe, 2'd0};
        vecs[1] = '{16'd160, 16'd210,   5'd1, 5'd1, 1'b0, SServe, 2'd0};
        vecs[2] = '{16'd300, 16'd250,   5'd2, 5'd1, 1'b0, SServe, 2'd0};
        vecs[3] = '{16'd0,   16'd65535, 5'd2, 5'd2, 1'b1, SServe, 2'd0};
        vecs[4] = '{16'd161, 16'd200,   5'd3, 5'd2, 1'b0, SOver,  2'd1};
        vecs[5] = '{16'd10,  16'd200,   5'd0, 5'd1, 1'b1, SServe, 2'd0};
        vecs[6] = '{16'd159, 16'd220,   5'd0, 5'd2, 1'b1, SServe, 2'd0};
        vecs[7] = '{16'd159, 16'd200,   5'd0, 5'd3, 1'b1, SOver,  2'd2};
        vecs[8] = '{16'd10,  16'd200,   5'd0, 5'd1, 1'b1, SServe, 2'd0};

        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'(SIdle));
        check("rst_score_p1", 32'(score_p1), 32'd0);
        check("rst_score_p2", 32'(score_p2), 32'd0);
        check("rst_serve_side", 32'(serve_side), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_physics_en", 32'(physics_en), 32'd0);
        check("rst_pulses", 32'({ball_reset, players_reset, frame_tick}), 32'd0);
        rst = 1'b1;

        // Divider period in IDLE.
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (frame_tick) hit = 1'b1;
        end
        check("first_tick", 32'(hit), 32'd1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!frame_tick && t < 20);
        check("tick_period", 32'(t), 32'd4);

        pulse_start();
        check("start_state", 32'(state), 32'(SServe));
        check("start_ball_reset", 32'(ball_reset), 32'd1);
        check("start_players_reset", 32'(players_reset), 32'd1);
        check("serve_physics_off", 32'(physics_en), 32'd0);
        t0 = frame_tick ? 1 : 0;
        @(negedge clk);
        check("pulse_width", 32'({ball_reset, players_reset}), 32'd0);
        count_ticks_in(SServe, 60, t);
        check("serve_ticks", 32'(t0 + t), 32'd2);
        check("rally_state", 32'(state), 32'(SRally));
        check("rally_physics_on", 32'(physics_en), 32'd1);

        // Just above the floor: no landing.
        ball_x = 16'd100;
        ball_y = 16'd199;
        repeat (6) @(negedge clk);
        check("no_land_state", 32'(state), 32'(SRally));
        check("no_land_score", 32'({score_p1, score_p2}), 32'd0);
        ball_y = 16'd0;

        pulse_start();
        check("start_ignored_rally", 32'(state), 32'(SRally));
        check("start_ignored_pulse", 32'(ball_reset), 32'd0);

        for (int i = 0; i < 5; i++) begin
            wait_state(SRally, 60, $sformatf("v%0d_reach_rally", i));
            land_vec(vecs[i], $sformatf("v%0d", i));
        end

        repeat (8) @(negedge clk);
        check("over_hold_state", 32'(state), 32'(SOver));
        check("over_hold_scores", 32'({score_p1, score_p2}), 32'({5'd3, 5'd2}));
        check("over_hold_winner", 32'(winner), 32'd1);
        check("over_physics_off", 32'(physics_en), 32'd0);

        pulse_start();
        check("restart_state", 32'(state), 32'(SServe));
        check("restart_scores", 32'({score_p1, score_p2}), 32'd0);
        check("restart_winner", 32'(winner), 32'd0);
        check("restart_serve_side", 32'(serve_side), 32'd0);
        check("restart_pulses", 32'({ball_reset, players_reset}), 32'd3);

        for (int i = 5; i < 8; i++) begin
            wait_state(SRally, 60, $sformatf("v%0d_reach_rally", i));
            land_vec(vecs[i], $sformatf("v%0d", i));
        end

        pulse_start();
        wait_state(SRally, 60, "g3_reach_rally");

`ifdef RALLY_PAUSE_EN
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("pause_state", 32'(state), 32'(SPause));
        check("pause_physics_off", 32'(physics_en), 32'd0);
        t = 0;
        for (int i = 0; i < 12; i++) begin
            if (frame_tick) t++;
            @(negedge clk);
        end
        check("pause_no_ticks", 32'(t), 32'd0);
        check("pause_held", 32'(state), 32'(SPause));
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("resume_state", 32'(state), 32'(SRally));
        check("resume_physics_on", 32'(physics_en), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 6 && !hit; i++) begin
            @(negedge clk);
            if (frame_tick) hit = 1'b1;
        end
        check("resume_tick", 32'(hit), 32'd1);
`endif

        land_vec(vecs[8], "v8");
        wait_state(SRally, 60, "v8_reach_rally");

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'(SIdle));
        check("async_rst_scores", 32'({score_p1, score_p2}), 32'd0);
        check("async_rst_physics", 32'(physics_en), 32'd0);
        check("async_rst_serve_side", 32'(serve_side), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(state), 32'(SIdle));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
